// File: rtl/amo_port_arbiter_if.sv
// Requester-side and cache-side AMO signals of amo_port_arbiter, bundled.
// The arbiter uses the slave view; the environment (requesters + cache) uses the master view.
interface amo_port_arbiter_if #(
  parameter int NrPorts = 2,
  parameter int XLEN    = 64,
  parameter int PLEN    = 56,
  parameter int CLEN    = 128,
  parameter int TagW    = 1,
  parameter int SizeW   = 2,
  parameter int OpW     = 4
) ();
  logic [NrPorts-1:0]            req_valid_i;
  logic [NrPorts-1:0][OpW-1:0]   req_op_i;
  logic [NrPorts-1:0][PLEN-1:0]  req_paddr_i;
  logic [NrPorts-1:0][CLEN-1:0]  req_data_i;
  logic [NrPorts-1:0][TagW-1:0]  req_tag_i;
  logic [NrPorts-1:0][SizeW-1:0] req_size_i;
  logic [NrPorts-1:0]            req_gnt_o;
  logic [NrPorts-1:0]            resp_valid_o;
  logic [CLEN-1:0]               resp_result_o;
  logic [TagW-1:0]               resp_tag_o;
  logic                          amo_req_o;
  logic [OpW-1:0]                amo_op_o;
  logic [SizeW-1:0]              amo_size_o;
  logic [XLEN-1:0]               amo_operand_a_o;
  logic [CLEN-1:0]               amo_operand_b_o;
  logic [TagW-1:0]               amo_cap_vld_o;
  logic                          amo_ack_i;
  logic [CLEN-1:0]               amo_result_i;
  logic [TagW-1:0]               amo_result_tag_i;

  modport slave (
    input  req_valid_i, req_op_i, req_paddr_i, req_data_i, req_tag_i, req_size_i,
    input  amo_ack_i, amo_result_i, amo_result_tag_i,
    output req_gnt_o, resp_valid_o, resp_result_o, resp_tag_o,
    output amo_req_o, amo_op_o, amo_size_o, amo_operand_a_o, amo_operand_b_o, amo_cap_vld_o
  );

  modport master (
    output req_valid_i, req_op_i, req_paddr_i, req_data_i, req_tag_i, req_size_i,
    output amo_ack_i, amo_result_i, amo_result_tag_i,
    input  req_gnt_o, resp_valid_o, resp_result_o, resp_tag_o,
    input  amo_req_o, amo_op_o, amo_size_o, amo_operand_a_o, amo_operand_b_o, amo_cap_vld_o
  );
endinterface

// File: rtl/amo_port_arbiter.sv
// Round-robin arbiter sharing one data-cache AMO port among NrPorts requesters,
// with a single outstanding AMO and flush-driven response suppression.
module amo_port_arbiter #(
  parameter int NrPorts = 2,
  parameter int XLEN    = 64,
  parameter int PLEN    = 56,
  parameter int CLEN    = 128,
  parameter int TagW    = 1,
  parameter int SizeW   = 2,
  parameter int OpW     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  amo_port_arbiter_if.slave  bus
);

  localparam int PtrW = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e              r_state;
  logic [PtrW-1:0]     r_owner;
  logic [PtrW-1:0]     r_rr_ptr;
  logic                r_drop;
  logic                r_amo_req;
  logic [OpW-1:0]      r_op;
  logic [SizeW-1:0]    r_size;
  logic [XLEN-1:0]     r_operand_a;
  logic [CLEN-1:0]     r_operand_b;
  logic [TagW-1:0]     r_cap_vld;
  logic [NrPorts-1:0]  r_resp_valid;
  logic [CLEN-1:0]     r_resp_result;
  logic [TagW-1:0]     r_resp_tag;

  logic [PtrW-1:0]     w_winner;
  logic [PtrW-1:0]     w_next_ptr;
  logic                w_found;
  logic                w_grant;

  // First valid port at or after the round-robin pointer, wrapping around.
  always_comb begin : p_winner
    int idx;
    // NOTE: every variable gets a default first so no path can infer a latch.
    idx      = 0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NrPorts) idx = idx - NrPorts;
      if (!w_found && bus.req_valid_i[PtrW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = PtrW'(idx);
      end
    end
  end

  // Reset is folded in so the combinational grant is also quiet during reset.
  assign w_grant    = (r_state == ST_IDLE) && !flush_i && w_found && !rst_i;
  assign w_next_ptr = (w_winner == PtrW'(NrPorts - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_drop        <= 1'b0;
      r_amo_req     <= 1'b0;
      r_op          <= '0;
      r_size        <= '0;
      r_operand_a   <= '0;
      r_operand_b   <= '0;
      r_cap_vld     <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      r_resp_tag    <= '0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      r_resp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_op        <= bus.req_op_i[w_winner];
            r_size      <= bus.req_size_i[w_winner];
            r_operand_a <= XLEN'(bus.req_paddr_i[w_winner]);
            r_operand_b <= bus.req_data_i[w_winner];
            r_cap_vld   <= bus.req_tag_i[w_winner];
            r_owner     <= w_winner;
            r_rr_ptr    <= w_next_ptr;
            r_drop      <= 1'b0;
            r_amo_req   <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The cache request is never aborted; a flush only marks its response for discard.
          if (flush_i) r_drop <= 1'b1;
          if (bus.amo_ack_i) begin
            r_amo_req <= 1'b0;
            r_state   <= ST_IDLE;
            if (!r_drop && !flush_i) begin
              r_resp_valid[r_owner] <= 1'b1;
              r_resp_result         <= bus.amo_result_i;
              r_resp_tag            <= bus.amo_result_tag_i;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_gnt_o       = w_grant ? (NrPorts'(1) << w_winner) : '0;
  assign bus.resp_valid_o    = r_resp_valid;
  assign bus.resp_result_o   = r_resp_result;
  assign bus.resp_tag_o      = r_resp_tag;
  assign bus.amo_req_o       = r_amo_req;
  assign bus.amo_op_o        = r_op;
  assign bus.amo_size_o      = r_size;
  assign bus.amo_operand_a_o = r_operand_a;
  assign bus.amo_operand_b_o = r_operand_b;
  assign bus.amo_cap_vld_o   = r_cap_vld;

endmodule

// File: tb/tb_amo_port_arbiter.sv
// Bench for amo_port_arbiter (3 ports): directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_amo_port_arbiter;
  localparam int N     = 3;
  localparam int XLEN  = 64;
  localparam int PLEN  = 56;
  localparam int CLEN  = 128;
  localparam int TagW  = 1;
  localparam int SizeW = 2;
  localparam int OpW   = 4;
  localparam logic [OpW-1:0] AMO_ADD = 4'h4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  amo_port_arbiter_if #(.NrPorts(N), .XLEN(XLEN), .PLEN(PLEN), .CLEN(CLEN),
                        .TagW(TagW), .SizeW(SizeW), .OpW(OpW)) bus ();

  amo_port_arbiter #(.NrPorts(N), .XLEN(XLEN), .PLEN(PLEN), .CLEN(CLEN),
                     .TagW(TagW), .SizeW(SizeW), .OpW(OpW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Requesters: a pending request is held until the model says it was granted.
  logic [N-1:0]     pend;
  logic [OpW-1:0]   p_op   [N];
  logic [PLEN-1:0]  p_addr [N];
  logic [CLEN-1:0]  p_data [N];
  logic [TagW-1:0]  p_tag  [N];
  logic [SizeW-1:0] p_size [N];

  // Cache / flush stimulus for the next cycle (ack and flush are one-shot).
  logic            d_flush, d_ack;
  logic [CLEN-1:0] d_res;
  logic [TagW-1:0] d_rtag;

  // Reference model: one outstanding transaction, described by what it carries.
  bit               m_busy, m_drop;
  int               m_owner, m_rr, last_win;
  logic [OpW-1:0]   m_op;
  logic [PLEN-1:0]  m_addr;
  logic [CLEN-1:0]  m_data;
  logic [TagW-1:0]  m_tag;
  logic [SizeW-1:0] m_size;
  logic [N-1:0]     m_rv;
  logic [CLEN-1:0]  m_res;
  logic [TagW-1:0]  m_rtag;

  function automatic logic [CLEN-1:0] rand_wide();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_req(input int p, input logic [OpW-1:0] op, input logic [PLEN-1:0] addr,
                         input logic [CLEN-1:0] data, input logic [TagW-1:0] tag,
                         input logic [SizeW-1:0] size);
    pend[p] = 1'b1; p_op[p] = op; p_addr[p] = addr; p_data[p] = data;
    p_tag[p] = tag; p_size[p] = size;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.req_valid_i[i] = pend[i];
      bus.req_op_i[i]    = p_op[i];
      bus.req_paddr_i[i] = p_addr[i];
      bus.req_data_i[i]  = p_data[i];
      bus.req_tag_i[i]   = p_tag[i];
      bus.req_size_i[i]  = p_size[i];
    end
    flush                = d_flush;
    bus.amo_ack_i        = d_ack;
    bus.amo_result_i     = d_res;
    bus.amo_result_tag_i = d_rtag;
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_owner = 0; m_rr = 0; m_rv = '0;
  endtask

  // One clock cycle: drive at negedge, compare 1 ns later, then advance the model.
  task automatic step();
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    drive_inputs();
    #1;
    last_win = -1;
    if (!m_busy && !d_flush)
      for (int k = 0; k < N; k++)
        if (last_win < 0 && pend[(m_rr + k) % N]) last_win = (m_rr + k) % N;
    exp_gnt = '0;
    if (last_win >= 0) exp_gnt[last_win] = 1'b1;
    check("gnt", bus.req_gnt_o, exp_gnt);
    check("amo_req", bus.amo_req_o, m_busy);
    if (m_busy) begin
      check("amo_op", bus.amo_op_o, m_op);
      check("amo_size", bus.amo_size_o, m_size);
      check("amo_opa", bus.amo_operand_a_o, {{(XLEN-PLEN){1'b0}}, m_addr});
      check("amo_opb", bus.amo_operand_b_o, m_data);
      check("amo_cap", bus.amo_cap_vld_o, m_tag);
    end
    check("resp_valid", bus.resp_valid_o, m_rv);
    if (m_rv != '0) begin
      check("resp_result", bus.resp_result_o, m_res);
      check("resp_tag", bus.resp_tag_o, m_rtag);
    end
    m_rv = '0;
    if (m_busy) begin
      if (d_ack) begin
        if (!m_drop && !d_flush) begin
          m_rv[m_owner] = 1'b1;
          m_res  = d_res;
          m_rtag = d_rtag;
        end
        m_busy = 0;
      end
      if (d_flush) m_drop = 1;
    end else if (last_win >= 0) begin
      m_op = p_op[last_win]; m_addr = p_addr[last_win]; m_data = p_data[last_win];
      m_tag = p_tag[last_win]; m_size = p_size[last_win];
      m_owner = last_win; m_rr = (last_win + 1) % N;
      m_busy = 1; m_drop = 0;
      pend[last_win] = 1'b0;
    end
    d_flush = 1'b0;
    d_ack   = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; every output must read zero while it is held.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_inputs();
    #1;
    check("rst_gnt", bus.req_gnt_o, '0);
    check("rst_amo_req", bus.amo_req_o, '0);
    check("rst_op", bus.amo_op_o, '0);
    check("rst_size", bus.amo_size_o, '0);
    check("rst_opa", bus.amo_operand_a_o, '0);
    check("rst_opb", bus.amo_operand_b_o, '0);
    check("rst_cap", bus.amo_cap_vld_o, '0);
    check("rst_rv", bus.resp_valid_o, '0);
    check("rst_res", bus.resp_result_o, '0);
    check("rst_rtag", bus.resp_tag_o, '0);
    model_reset();
    pend = '0; d_flush = 1'b0; d_ack = 1'b0;
    drive_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gq[$];
    logic [N-1:0] exp_seq[4];
    pend = '0; d_flush = 1'b0; d_ack = 1'b0; d_res = '0; d_rtag = '0;
    for (int i = 0; i < N; i++) begin
      p_op[i] = '0; p_addr[i] = '0; p_data[i] = '0; p_tag[i] = '0; p_size[i] = '0;
    end
    model_reset();

    // Single request on port 0 from reset, ack three cycles after grant.
    do_reset();
    set_req(0, AMO_ADD, 56'h8000_1000, 128'h5, 1'b0, 2'b11);
    step();
    check("t1_gnt", bus.req_gnt_o, 3'b001);
    step();
    check("t1_req", bus.amo_req_o, 1'b1);
    check("t1_opa", bus.amo_operand_a_o, 64'h0000_0000_8000_1000);
    step();
    d_ack = 1'b1; d_res = 128'h7; d_rtag = 1'b0;
    step();
    step();
    check("t1_rv", bus.resp_valid_o, 3'b001);
    check("t1_res", bus.resp_result_o, 128'h7);

    // Ports 0 and 1 continuously valid; cache acks one cycle after each grant.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) set_req(p, OpW'($urandom), PLEN'(rand_wide()), rand_wide(), TagW'($urandom), SizeW'($urandom));
      d_ack = m_busy; d_res = rand_wide(); d_rtag = TagW'($urandom);
      step();
      if (last_win >= 0) gq.push_back(bus.req_gnt_o);
    end
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
    check("cont_count", gq.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      if (k < gq.size()) check($sformatf("cont_gnt%0d", k), gq[k], exp_seq[k]);
    pend = '0;

    // Wrap-around: move the pointer to 2, then ports 0 and 2 compete.
    do_reset();
    set_req(1, 4'h3, 56'h100, 128'h1, 1'b1, 2'b10);
    step();
    d_ack = 1'b1; d_res = 128'hAA; step();
    set_req(0, 4'h5, 56'h200, 128'h2, 1'b0, 2'b11);
    set_req(2, 4'h6, 56'h300, 128'h3, 1'b1, 2'b11);
    step();
    check("wrap_first", bus.req_gnt_o, 3'b100);
    d_ack = 1'b1; d_res = 128'hBB; step();
    step();
    check("wrap_second", bus.req_gnt_o, 3'b001);
    d_ack = 1'b1; d_res = 128'hCC; step();

    // Flush one cycle after grant, ack two cycles later: request held, response dropped.
    do_reset();
    set_req(1, AMO_ADD, 56'h400, 128'h9, 1'b0, 2'b11);
    step();
    d_flush = 1'b1; step();
    check("fl_req1", bus.amo_req_o, 1'b1);
    step();
    check("fl_req2", bus.amo_req_o, 1'b1);
    d_ack = 1'b1; d_res = 128'hDEAD; step();
    check("fl_req3", bus.amo_req_o, 1'b1);
    set_req(0, AMO_ADD, 56'h500, 128'h4, 1'b1, 2'b01);
    step();
    check("fl_rv", bus.resp_valid_o, 3'b000);
    check("fl_idle_gnt", bus.req_gnt_o, 3'b001);

    // Flush coincident with ack.
    step();
    d_ack = 1'b1; d_flush = 1'b1; d_res = 128'hBEEF; step();
    set_req(2, 4'h7, 56'h600, 128'h6, 1'b0, 2'b11);
    step();
    check("fa_rv", bus.resp_valid_o, 3'b000);
    check("fa_req", bus.amo_req_o, 1'b0);
    check("fa_idle_gnt", bus.req_gnt_o, 3'b100);
    d_ack = 1'b1; d_res = 128'h1234; step();

    // Spurious ack in IDLE, then reset while BUSY.
    step();
    d_ack = 1'b1; d_res = 128'h5555; step();
    check("sp_rv", bus.resp_valid_o, 3'b000);
    check("sp_req", bus.amo_req_o, 1'b0);
    set_req(0, AMO_ADD, 56'h700, 128'h8, 1'b1, 2'b11);
    step();
    step();
    set_req(1, AMO_ADD, 56'h800, 128'h9, 1'b0, 2'b11);
    do_reset();

    // Random traffic: requests, acks (including spurious ones) and flushes.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++)
        if (!pend[p] && $urandom_range(0, 2) == 0)
          set_req(p, OpW'($urandom), PLEN'(rand_wide()), rand_wide(), TagW'($urandom), SizeW'($urandom));
      d_flush = ($urandom_range(0, 15) == 0);
      d_ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      d_res   = rand_wide();
      d_rtag  = TagW'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
